mips_dmem_responder: RTL and testbench
======================================

Name: mips_dmem_responder

Overview:
- Data-memory responder serving the MIPS core's load/store requests, which the core initiates.
- Word-organised synchronous RAM with byte-lane writes behind a valid/ready request channel and a one-beat response channel.
- Configurable wait states model slow memory so the core's stall logic is exercised.
- Sits between the MIPS datapath MEM stage and the simulation top.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words. Power of two, at least 4.
- WAIT_CYCLES, 2: extra cycles between request accept and response. Range 0..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  responder accepts the request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables; bit i covers bits [8i+7:8i].
- resp_valid  out  1  response beat; exactly one per accepted request.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  misaligned or out-of-range access.

Behaviour:
- Reset values:
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
  - FSM goes to IDLE. Wait counter = 0.
  - Memory contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Handshake occurs when req_valid && req_ready on a rising edge.
  - At the handshake, capture we, addr, wdata and be.
  - Go to WAIT if WAIT_CYCLES>0, else go to RESP.
- WAIT:
  - req_ready=0.
  - Counter counts up from 0.
  - Leave for RESP on the cycle the counter equals WAIT_CYCLES-1.
- RESP:
  - resp_valid=1 for exactly one cycle, then return to IDLE.
  - There is no resp_ready; the core must sample the beat.
- Latency: response appears WAIT_CYCLES+1 cycles after the accept edge. Minimum 1 (WAIT_CYCLES=0).
- Throughput: one request per WAIT_CYCLES+2 cycles. req_ready is low in WAIT and RESP.
- Error checks:
  - Misaligned: req_addr[1:0]!=0 gives err=1.
  - Out of range: (addr-BASE_ADDR)>>2 >= DEPTH_WORDS gives err=1.
  - Errored stores do not modify memory.
  - Errored loads return resp_rdata=0.
- Store:
  - Memory is written at the RESP edge, only for lanes with be=1.
  - Response is resp_rdata=0, err=0.
  - be=4'b0000 is a legal no-op store.
- Load:
  - Reads the full word; req_be is ignored.
  - resp_rdata holds the data for the RESP cycle, then returns to 0.
- Address arithmetic: word index = (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2]. Subtraction is 32-bit and wraps.
- Request fields are don't-care while req_valid=0 or req_ready=0.
- Reset asserted mid-transaction (WAIT or RESP):
  - Transaction is aborted and no response is issued.
  - A pending store is not performed.
- Load immediately after a store to the same address returns the new data, because the write has completed at RESP.

Optional Feature:
- Macro: MIPS_DMEM_STATS_EN.
- When defined, adds two outputs:
  - rd_count (out, 32): successful loads.
  - wr_count (out, 32): successful stores.
- Counters update in the RESP cycle, exclude errored accesses, reset to 0, and wrap at 2^32.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package mips_mem_pkg holds:
  - FSM state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - Byte-enable width 4 and word width 32 constants.
  - Function for the word-index/range check.
- One sub-module: mips_dmem_ram.
  - Single-port, byte-write-enabled, DEPTH_WORDS×32, synchronous write, combinational read.
  - Instantiated once. The FSM stays in the top module.

Test Plan:
- Reset and idle: hold rst 3 cycles, then release. Required: req_ready=1 on the first cycle after release; resp_valid, resp_rdata and resp_err=0.
- Store then load, WAIT_CYCLES=2:
  - Store 0xDEADBEEF to 0x10 with be=4'hF. Required: resp_valid exactly 3 cycles after accept, err=0.
  - Then load 0x10. Required: resp_rdata=0xDEADBEEF.
- Byte lanes: word 0x20 holds 0x11223344; store 0xAABBCCDD with be=4'b0101; then load 0x20. Required: 0x11BB33DD.
- Errors:
  - Load from 0x13 (misaligned). Required: err=1, rdata=0.
  - Store to BASE_ADDR+4*DEPTH_WORDS. Required: err=1.
  - Load word 0 afterwards. Required: unchanged.
- Back-to-back, WAIT_CYCLES=0: req_valid held high for 4 requests. Required: req_ready toggles 1,0 each accept; 4 resp_valid beats, each 1 cycle after its accept.
- Mid-operation reset: assert rst during WAIT of a store to 0x40 (old value 0x5). Required: no resp_valid; a later load of 0x40 returns 0x5. With MIPS_DMEM_STATS_EN: wr_count=0.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory slice: widths, responder FSM
// state encoding and the address helpers used for indexing and range checks.
package mips_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } dmem_state_t;

  // Word offset of a byte address from the region base; the subtraction wraps.
  function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

  // A word offset at or beyond the array depth is outside the memory.
  function automatic logic word_out_of_range(input logic [31:0] word,
                                             input int unsigned depth);
    return word >= depth;
  endfunction

endpackage

// File: rtl/mips_dmem_ram.sv
// Single-port word RAM with per-byte write enables: synchronous write,
// combinational read at the same address.
module mips_dmem_ram
  import mips_mem_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 256,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Write only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the MIPS MEM stage: valid/ready request channel,
// configurable wait states, one-beat response with error flag.
// Optional MIPS_DMEM_STATS_EN adds rd_count/wr_count success counters.
module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
`ifdef MIPS_DMEM_STATS_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam int unsigned WAIT_LAST = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  dmem_state_t state, next_state;
  logic [3:0]        wait_cnt;
  logic              accept;
  logic [31:0]       req_word;
  logic              req_err;

  logic              cap_we;
  logic              cap_err;
  logic [WORD_W-1:0] cap_wdata;
  logic [BE_W-1:0]   cap_be;
  logic [AW-1:0]     cap_idx;

  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;

  assign accept   = req_valid && req_ready;
  assign req_word = word_offset(req_addr, BASE_ADDR);
  assign req_err  = (req_addr[1:0] != 2'b00) || word_out_of_range(req_word, DEPTH_WORDS);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Wait-state counter: runs only while in WAIT, cleared everywhere else.
  always_ff @(posedge clk) begin
    if (rst)                 wait_cnt <= '0;
    else if (state == S_WAIT) wait_cnt <= wait_cnt + 4'd1;
    else                     wait_cnt <= '0;
  end

  // Request capture at the handshake; the error verdict is decided up front.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_we    <= req_we;
      cap_err   <= req_err;
      cap_wdata <= req_wdata;
      cap_be    <= req_be;
      cap_idx   <= req_word[AW-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (accept) next_state = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (wait_cnt == 4'(WAIT_LAST)) next_state = S_RESP;
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs and RAM write strobe; reset masks everything so an interrupted
  // transaction neither responds nor commits its store.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    ram_we     = 1'b0;
    if (!rst) begin
      unique case (state)
        S_IDLE: req_ready = 1'b1;
        S_RESP: begin
          resp_valid = 1'b1;
          resp_err   = cap_err;
          ram_we     = cap_we && !cap_err;
          if (!cap_we && !cap_err) resp_rdata = ram_rdata;
        end
        default: ;
      endcase
    end
  end

  mips_dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .be   (cap_be),
    .addr (cap_idx),
    .wdata(cap_wdata),
    .rdata(ram_rdata)
  );

`ifdef MIPS_DMEM_STATS_EN
  // Count successful loads and stores as their response beat completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (resp_valid && !cap_err) begin
      if (cap_we) wr_count <= wr_count + 32'd1;
      else        rd_count <= rd_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Self-checking bench: instance A (WAIT_CYCLES=2, base 0, 256 words) and
// instance B (WAIT_CYCLES=0, base 0x100, 16 words), checked against a
// word-array reference model.
module tb_mips_dmem_responder;

  localparam int unsigned DEPTH_A = 256;
  localparam int unsigned WAIT_A  = 2;
  localparam logic [31:0] BASE_A  = 32'h0000_0000;
  localparam int unsigned DEPTH_B = 16;
  localparam int unsigned WAIT_B  = 0;
  localparam logic [31:0] BASE_B  = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        va = 1'b0, wea = 1'b0, ra, rva, ea;
  logic [31:0] aa = '0, wda = '0, rda;
  logic [3:0]  bea = '0;
  logic        vb = 1'b0, web = 1'b0, rb, rvb, eb;
  logic [31:0] ab = '0, wdb = '0, rdb;
  logic [3:0]  beb = '0;
`ifdef MIPS_DMEM_STATS_EN
  logic [31:0] rdc_a, wrc_a, rdc_b, wrc_b;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_rd_a = 0;
  int exp_wr_a = 0;

  always #5 clk = ~clk;

  mips_dmem_responder #(.DEPTH_WORDS(DEPTH_A), .WAIT_CYCLES(WAIT_A), .BASE_ADDR(BASE_A)) dut_a (
    .clk(clk), .rst(rst), .req_valid(va), .req_ready(ra), .req_we(wea), .req_addr(aa),
    .req_wdata(wda), .req_be(bea), .resp_valid(rva), .resp_rdata(rda), .resp_err(ea)
`ifdef MIPS_DMEM_STATS_EN
    , .rd_count(rdc_a), .wr_count(wrc_a)
`endif
  );

  mips_dmem_responder #(.DEPTH_WORDS(DEPTH_B), .WAIT_CYCLES(WAIT_B), .BASE_ADDR(BASE_B)) dut_b (
    .clk(clk), .rst(rst), .req_valid(vb), .req_ready(rb), .req_we(web), .req_addr(ab),
    .req_wdata(wdb), .req_be(beb), .resp_valid(rvb), .resp_rdata(rdb), .resp_err(eb)
`ifdef MIPS_DMEM_STATS_EN
    , .rd_count(rdc_b), .wr_count(wrc_b)
`endif
  );

  // One transaction on instance A, started at a negedge. Returns the response
  // fields, latency in cycles from the accept edge, and the beat-after values.
  task automatic txn_a(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] rd, output logic er,
                       output int lat, output logic rv_after, output logic [31:0] rd_after);
    int guard = 0;
    wea = we; aa = a; wda = d; bea = be; va = 1'b1;
    while (!ra && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    va = 1'b0; wea = 1'($urandom); aa = $urandom; wda = $urandom; bea = 4'($urandom);
    lat = 1;
    while (!rva && lat < 40) begin @(negedge clk); lat++; end
    rd = rda; er = ea;
    @(negedge clk);
    rv_after = rva; rd_after = rda;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (ra !== 1'b1) begin failures++; $display("FAIL reset_ready_a: got %b want 1", ra); end
    checks++; if (rb !== 1'b1) begin failures++; $display("FAIL reset_ready_b: got %b want 1", rb); end
    checks++; if ({rva, ea, rda} !== 34'd0) begin failures++; $display("FAIL reset_resp_a: valid=%b err=%b rdata=%h want 0", rva, ea, rda); end
    checks++; if ({rvb, eb, rdb} !== 34'd0) begin failures++; $display("FAIL reset_resp_b: valid=%b err=%b rdata=%h want 0", rvb, eb, rdb); end
`ifdef MIPS_DMEM_STATS_EN
    checks++; if ({rdc_a, wrc_a} !== 64'd0) begin failures++; $display("FAIL reset_stats: rd=%0d wr=%0d want 0", rdc_a, wrc_a); end
`endif
    @(negedge clk);
  endtask

  task automatic test_store_load();
    logic [31:0] rd, rd2; logic er, rv2; int lat;
    txn_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, rv2, rd2);
    exp_wr_a++;
    checks++; if (lat !== WAIT_A + 1) begin failures++; $display("FAIL store_latency: got %0d want %0d", lat, WAIT_A + 1); end
    checks++; if ({er, rd} !== 33'd0) begin failures++; $display("FAIL store_resp: err=%b rdata=%h want 0", er, rd); end
    checks++; if (rv2 !== 1'b0) begin failures++; $display("FAIL store_single_beat: valid=%b want 0", rv2); end
    txn_a(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, rv2, rd2);
    exp_rd_a++;
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin failures++; $display("FAIL load_after_store: rdata=%h err=%b want deadbeef 0", rd, er); end
    checks++; if (rd2 !== 32'h0) begin failures++; $display("FAIL load_rdata_return0: got %h want 0", rd2); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd, rd2; logic er, rv2; int lat;
    txn_a(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat, rv2, rd2);
    txn_a(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat, rv2, rd2);
    txn_a(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, rv2, rd2);
    checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL byte_lanes: got %h want 11bb33dd", rd); end
    txn_a(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat, rv2, rd2);
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL be0_err: got %b want 0", er); end
    txn_a(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat, rv2, rd2);
    checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL be0_noop: got %h want 11bb33dd", rd); end
    exp_wr_a += 3; exp_rd_a += 2;
  endtask

  task automatic test_errors();
    logic [31:0] rd, rd2; logic er, rv2; int lat;
    txn_a(1'b1, 32'h0, 32'h0BADF00D, 4'hF, rd, er, lat, rv2, rd2);
    txn_a(1'b0, 32'h13, 32'h0, 4'hF, rd, er, lat, rv2, rd2);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL misaligned_load: err=%b rdata=%h want 1 0", er, rd); end
    txn_a(1'b1, BASE_A + 4 * DEPTH_A, 32'hFFFFFFFF, 4'hF, rd, er, lat, rv2, rd2);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL range_store_err: got %b want 1", er); end
    checks++; if (lat !== WAIT_A + 1) begin failures++; $display("FAIL err_latency: got %0d want %0d", lat, WAIT_A + 1); end
    txn_a(1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat, rv2, rd2);
    checks++; if (rd !== 32'h0BADF00D || er !== 1'b0) begin failures++; $display("FAIL word0_unchanged: rdata=%h err=%b want 0badf00d 0", rd, er); end
    exp_wr_a++; exp_rd_a++;
  endtask

  task automatic test_back_to_back();
    logic        tw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ta [4] = '{32'h104, 32'h104, 32'h106, 32'h140};
    logic [31:0] td [4] = '{32'hCAFEF00D, 32'h0, 32'h1234, 32'h0};
    logic [31:0] xr [4] = '{32'h0, 32'hCAFEF00D, 32'h0, 32'h0};
    logic        xe [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int k = 0;
    web = tw[0]; ab = ta[0]; wdb = td[0]; beb = 4'hF; vb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic exp_ready;
      exp_ready = (i % 2 == 0);
      checks++; if (rb !== exp_ready) begin failures++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, rb, exp_ready); end
      checks++; if (rvb !== !exp_ready) begin failures++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, rvb, !exp_ready); end
      if (rvb) begin
        checks++; if (rdb !== xr[i/2] || eb !== xe[i/2]) begin failures++; $display("FAIL b2b_beat[%0d]: rdata=%h err=%b want %h %b", i/2, rdb, eb, xr[i/2], xe[i/2]); end
      end
      if (!rb) begin
        k++;
        if (k < 4) begin web = tw[k]; ab = ta[k]; wdb = td[k]; end
        else vb = 1'b0;
      end
      @(negedge clk);
    end
`ifdef MIPS_DMEM_STATS_EN
    checks++; if (rdc_b !== 32'd1 || wrc_b !== 32'd1) begin failures++; $display("FAIL b2b_stats: rd=%0d wr=%0d want 1 1", rdc_b, wrc_b); end
`endif
  endtask

  task automatic test_mid_reset();
    logic [31:0] rd, rd2; logic er, rv2; int lat;
    logic seen;
    // Reset while waiting.
    txn_a(1'b1, 32'h40, 32'h5, 4'hF, rd, er, lat, rv2, rd2);
    wea = 1'b1; aa = 32'h40; wda = 32'hFFFFFFFF; bea = 4'hF; va = 1'b1;
    @(negedge clk);
    rst = 1'b1; va = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen |= rva; end
    rst = 1'b0;
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL wait_reset_no_resp: got valid=%b want 0", seen); end
`ifdef MIPS_DMEM_STATS_EN
    checks++; if (wrc_a !== 32'd0) begin failures++; $display("FAIL wait_reset_wrcount: got %0d want 0", wrc_a); end
`endif
    txn_a(1'b0, 32'h40, 32'h0, 4'hF, rd, er, lat, rv2, rd2);
    checks++; if (rd !== 32'h5) begin failures++; $display("FAIL wait_reset_mem: got %h want 5", rd); end
    // Reset while the response beat is up.
    txn_a(1'b1, 32'h44, 32'h7, 4'hF, rd, er, lat, rv2, rd2);
    wea = 1'b1; aa = 32'h44; wda = 32'hFFFFFFFF; bea = 4'hF; va = 1'b1;
    @(negedge clk); va = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (rva !== 1'b0) begin failures++; $display("FAIL resp_reset_no_resp: got %b want 0", rva); end
    @(negedge clk); rst = 1'b0;
    txn_a(1'b0, 32'h44, 32'h0, 4'hF, rd, er, lat, rv2, rd2);
    checks++; if (rd !== 32'h7) begin failures++; $display("FAIL resp_reset_mem: got %h want 7", rd); end
    exp_wr_a = 0; exp_rd_a = 1;
  endtask

  task automatic test_random();
    logic [31:0] mdl [16];
    logic [31:0] rd, rd2, a, d, exp_rd; logic er, rv2, we, exp_err; logic [3:0] be; int lat;
    for (int w = 0; w < 16; w++) begin
      mdl[w] = $urandom;
      txn_a(1'b1, 32'h80 + 4 * w, mdl[w], 4'hF, rd, er, lat, rv2, rd2);
      exp_wr_a++;
    end
    for (int n = 0; n < 40; n++) begin
      int kind, idx;
      kind = $urandom_range(0, 9);
      we = 1'($urandom); d = $urandom; be = 4'($urandom);
      idx = $urandom_range(0, 15);
      if (kind < 7)       a = 32'h80 + 4 * idx;
      else if (kind == 7) a = 32'h80 + 4 * idx + $urandom_range(1, 3);
      else if (kind == 8) a = 32'h400 + 4 * $urandom_range(0, 255);
      else                a = 32'hFFFF_FFFC;
      exp_err = (a % 4 != 0) || ((a - BASE_A) / 4 >= DEPTH_A);
      exp_rd  = (we || exp_err) ? 32'h0 : mdl[idx];
      txn_a(we, a, d, be, rd, er, lat, rv2, rd2);
      if (!exp_err) begin
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) mdl[idx] = (mdl[idx] & ~(32'hFF << (8 * b))) | (d & (32'hFF << (8 * b)));
          exp_wr_a++;
        end else exp_rd_a++;
      end
      checks++; if (er !== exp_err || rd !== exp_rd) begin failures++; $display("FAIL rand[%0d] %s %h: rdata=%h err=%b want %h %b", n, we ? "st" : "ld", a, rd, er, exp_rd, exp_err); end
      checks++; if (lat !== WAIT_A + 1 || rv2 !== 1'b0) begin failures++; $display("FAIL rand_timing[%0d]: lat=%0d after=%b want %0d 0", n, lat, rv2, WAIT_A + 1); end
    end
`ifdef MIPS_DMEM_STATS_EN
    checks++; if (rdc_a !== 32'(exp_rd_a) || wrc_a !== 32'(exp_wr_a)) begin failures++; $display("FAIL rand_stats: rd=%0d wr=%0d want %0d %0d", rdc_a, wrc_a, exp_rd_a, exp_wr_a); end
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_errors();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

endmodule
